// File: rtl/forwarding_pkg.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_pkg
// Purpose  : Shared constants, compare-record type and helpers for the
//            operand-forwarding monitor.
// Revision : 1.0 - initial release
// ============================================================================
package forwarding_pkg;

  // Datapath width the compare record is sized for; the monitor's XLEN must
  // not exceed this.
  localparam int unsigned FWD_XLEN   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One per-port entry of the compare stage.
  typedef struct packed {
    logic                fail;
    logic [FWD_XLEN-1:0] exp;
    logic [FWD_XLEN-1:0] act;
  } cmp_rec_t;

  // Number of set bits in a vector of up to 32 ports.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage : forwarding_pkg
`default_nettype wire

// File: rtl/forwarding_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_monitor_if
// Purpose  : Taps on the EX stage, the post-EX bypass stages and retirement
//            observed by the forwarding monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface forwarding_monitor_if
  import forwarding_pkg::*;
#(
  parameter int XLEN    = FWD_XLEN,
  parameter int NPORTS  = 2,
  parameter int NSTAGES = 2
);

  logic                             ex_valid_i;
  logic                             stall_i;
  logic                             flush_i;
  logic [NPORTS-1:0]                ex_rs_used_i;
  logic [NPORTS-1:0][REG_ADDR_W-1:0] ex_rs_addr_i;
  logic [NPORTS-1:0][XLEN-1:0]      ex_rs_data_i;
  logic [NSTAGES-1:0]               stage_we_i;
  logic [NSTAGES-1:0][REG_ADDR_W-1:0] stage_rd_i;
  logic [NSTAGES-1:0][XLEN-1:0]     stage_data_i;
  logic                             retire_we_i;
  logic [REG_ADDR_W-1:0]            retire_rd_i;
  logic [XLEN-1:0]                  retire_data_i;

  // Pipeline side drives the taps.
  modport master (
    output ex_valid_i, stall_i, flush_i, ex_rs_used_i, ex_rs_addr_i,
           ex_rs_data_i, stage_we_i, stage_rd_i, stage_data_i,
           retire_we_i, retire_rd_i, retire_data_i
  );

  // Monitor side only observes.
  modport slave (
    input  ex_valid_i, stall_i, flush_i, ex_rs_used_i, ex_rs_addr_i,
           ex_rs_data_i, stage_we_i, stage_rd_i, stage_data_i,
           retire_we_i, retire_rd_i, retire_data_i
  );

endinterface : forwarding_monitor_if
`default_nettype wire

// File: rtl/fwd_expected_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_expected_sel
// Purpose  : Architecturally expected value of one EX source operand:
//            x0, then youngest matching bypass stage, then the retire
//            write, then the shadow register file.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_expected_sel
  import forwarding_pkg::*;
#(
  parameter int XLEN    = FWD_XLEN,
  parameter int NSTAGES = 2
) (
  input  wire logic [REG_ADDR_W-1:0]              i_rs_addr,
  input  wire logic [NSTAGES-1:0]                 i_stage_we,
  input  wire logic [NSTAGES-1:0][REG_ADDR_W-1:0] i_stage_rd,
  input  wire logic [NSTAGES-1:0][XLEN-1:0]       i_stage_data,
  input  wire logic                               i_retire_we,
  input  wire logic [REG_ADDR_W-1:0]              i_retire_rd,
  input  wire logic [XLEN-1:0]                    i_retire_data,
  input  wire logic [31:1][XLEN-1:0]              i_shadow,
  output logic      [XLEN-1:0]                    o_exp
);

  // Oldest source first so that younger producers overwrite the choice;
  // the loop runs oldest-to-youngest so stage 0 ends up with top priority.
  always_comb begin
    o_exp = '0;
    if (i_rs_addr != REG_ZERO) begin
      o_exp = i_shadow[i_rs_addr];
      if (i_retire_we && (i_retire_rd == i_rs_addr)) begin
        o_exp = i_retire_data;
      end
      for (int s = NSTAGES - 1; s >= 0; s--) begin
        if (i_stage_we[s] && (i_stage_rd[s] == i_rs_addr)) begin
          o_exp = i_stage_data[s];
        end
      end
    end
  end

endmodule : fwd_expected_sel
`default_nettype wire

// File: rtl/forwarding_monitor.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_monitor
// Purpose  : Run-time checker of EX-stage operand forwarding. Keeps a shadow
//            register file from retirement, derives the expected value of
//            every qualified source operand and flags any disagreement with
//            what the datapath delivered.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_monitor
  import forwarding_pkg::*;
#(
  parameter  int XLEN    = FWD_XLEN,
  parameter  int NPORTS  = 2,
  parameter  int NSTAGES = 2,
  parameter  int CNT_W   = 16,
  localparam int PORT_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  wire logic               clk,
  input  wire logic               reset,      // active-low, asynchronous
  forwarding_monitor_if.slave     bus,
  input  wire logic               err_clr_i,
  output logic                    mismatch_o,
  output logic [PORT_W-1:0]       mismatch_port_o,
  output logic [XLEN-1:0]         mismatch_exp_o,
  output logic [XLEN-1:0]         mismatch_act_o,
  output logic                    error_o,
  output logic [CNT_W-1:0]        check_cnt_o,
  output logic [CNT_W-1:0]        err_cnt_o
);

  // Saturating add of a small event count onto a counter.
  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0]       b);
    logic [CNT_W+5:0] sum;
    sum = {6'd0, a} + {{CNT_W{1'b0}}, b};
    if (sum > {6'd0, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  logic [31:1][XLEN-1:0]      r_shadow;
  logic [NPORTS-1:0][XLEN-1:0] w_exp;
  logic [NPORTS-1:0]          w_qual;
  logic [NPORTS-1:0]          w_fail;
  logic [5:0]                 w_qual_cnt;
  logic [5:0]                 w_fail_cnt;

  cmp_rec_t                   r_cmp [NPORTS];
  logic [NPORTS-1:0]          r_cmp_qual;
  logic [NPORTS-1:0]          w_fail_q;
  logic                       w_any_fail;
  logic [PORT_W-1:0]          w_low_idx;
  logic [XLEN-1:0]            r_exp_hold;
  logic [XLEN-1:0]            r_act_hold;
  logic                       r_error;
  logic [CNT_W-1:0]           r_check_cnt;
  logic [CNT_W-1:0]           r_err_cnt;

  // Shadow register file: x0 is never stored, writes come from retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (bus.retire_we_i && (bus.retire_rd_i != REG_ZERO)) begin
      r_shadow[bus.retire_rd_i] <= bus.retire_data_i;
    end
  end

  // One expected-value selector and comparator per EX read port.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_expected_sel #(
      .XLEN    (XLEN),
      .NSTAGES (NSTAGES)
    ) u_sel (
      .i_rs_addr     (bus.ex_rs_addr_i[p]),
      .i_stage_we    (bus.stage_we_i),
      .i_stage_rd    (bus.stage_rd_i),
      .i_stage_data  (bus.stage_data_i),
      .i_retire_we   (bus.retire_we_i),
      .i_retire_rd   (bus.retire_rd_i),
      .i_retire_data (bus.retire_data_i),
      .i_shadow      (r_shadow),
      .o_exp         (w_exp[p])
    );

    // Only the final EX cycle of a live instruction is checked.
    assign w_qual[p] = bus.ex_valid_i && !bus.stall_i && !bus.flush_i &&
                       bus.ex_rs_used_i[p];
    assign w_fail[p] = w_qual[p] && (w_exp[p] != bus.ex_rs_data_i[p]);
  end

  assign w_qual_cnt = popcount32(32'(w_qual));
  assign w_fail_cnt = popcount32(32'(w_fail));

  // Compare stage: capture per-port verdict, expected and delivered values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        r_cmp[p] <= '0;
      end
      r_cmp_qual <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        r_cmp[p].fail <= w_fail[p];
        r_cmp[p].exp  <= FWD_XLEN'(w_exp[p]);
        r_cmp[p].act  <= FWD_XLEN'(bus.ex_rs_data_i[p]);
      end
      r_cmp_qual <= w_qual;
    end
  end

  // Lowest-index failing port of the registered compare results.
  always_comb begin
    w_low_idx = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_fail_q[p] = r_cmp[p].fail && r_cmp_qual[p];
    end
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (w_fail_q[p]) begin
        w_low_idx = PORT_W'(p);
      end
    end
    w_any_fail = |w_fail_q;
  end

  // Remember the last reported failure so it stays visible between events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_hold <= '0;
      r_act_hold <= '0;
    end else if (w_any_fail) begin
      r_exp_hold <= r_cmp[w_low_idx].exp[XLEN-1:0];
      r_act_hold <= r_cmp[w_low_idx].act[XLEN-1:0];
    end
  end

  // Sticky error and saturating counters; a fresh failure beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error     <= 1'b0;
      r_check_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_check_cnt <= f_sat_add(r_check_cnt, w_qual_cnt);
      r_err_cnt   <= f_sat_add(err_clr_i ? '0 : r_err_cnt, w_fail_cnt);
      r_error     <= (err_clr_i ? 1'b0 : r_error) | (|w_fail);
    end
  end

  assign mismatch_o      = w_any_fail;
  assign mismatch_port_o = w_low_idx;
  assign mismatch_exp_o  = w_any_fail ? r_cmp[w_low_idx].exp[XLEN-1:0] : r_exp_hold;
  assign mismatch_act_o  = w_any_fail ? r_cmp[w_low_idx].act[XLEN-1:0] : r_act_hold;
  assign error_o         = r_error;
  assign check_cnt_o     = r_check_cnt;
  assign err_cnt_o       = r_err_cnt;

endmodule : forwarding_monitor
`default_nettype wire

// File: tb/tb_forwarding_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_forwarding_monitor
// Purpose  : Self-checking bench for forwarding_monitor (16-bit and 2-bit
//            counter instances side by side on the same taps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_forwarding_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err_clr = 1'b0;

  always #5 clk = ~clk;

  forwarding_monitor_if #(.XLEN(32), .NPORTS(2), .NSTAGES(2)) bus();

  logic        mm, mm_s, err, err_s;
  logic [0:0]  mport, mport_s;
  logic [31:0] mexp, mexp_s, mact, mact_s;
  logic [15:0] chkc, errc;
  logic [1:0]  chkc_s, errc_s;

  forwarding_monitor #(.XLEN(32), .NPORTS(2), .NSTAGES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .err_clr_i(err_clr),
    .mismatch_o(mm), .mismatch_port_o(mport), .mismatch_exp_o(mexp),
    .mismatch_act_o(mact), .error_o(err), .check_cnt_o(chkc), .err_cnt_o(errc)
  );

  forwarding_monitor #(.XLEN(32), .NPORTS(2), .NSTAGES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus), .err_clr_i(err_clr),
    .mismatch_o(mm_s), .mismatch_port_o(mport_s), .mismatch_exp_o(mexp_s),
    .mismatch_act_o(mact_s), .error_o(err_s), .check_cnt_o(chkc_s), .err_cnt_o(errc_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_shadow [32];
  int          m_chk, m_err, m_chk_s, m_err_s;
  bit          m_error, m_mm;
  int          m_port;
  logic [31:0] m_exp, m_act;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
    m_chk = 0; m_err = 0; m_chk_s = 0; m_err_s = 0;
    m_error = 0; m_mm = 0; m_port = 0; m_exp = '0; m_act = '0;
  endtask

  function automatic logic [31:0] m_expect(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int s = 0; s < 2; s++)
      if (bus.stage_we_i[s] && bus.stage_rd_i[s] == a) return bus.stage_data_i[s];
    if (bus.retire_we_i && bus.retire_rd_i == a) return bus.retire_data_i;
    return m_shadow[a];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Called at each active edge with the inputs that were sampled there.
  task automatic model_step();
    int nq = 0, nf = 0, first = -1;
    logic [31:0] fe = '0, fa = '0;
    for (int p = 0; p < 2; p++) begin
      logic [31:0] e;
      bit q;
      q = bus.ex_valid_i && !bus.stall_i && !bus.flush_i && bus.ex_rs_used_i[p];
      e = m_expect(bus.ex_rs_addr_i[p]);
      if (q) nq++;
      if (q && e !== bus.ex_rs_data_i[p]) begin
        nf++;
        if (first < 0) begin first = p; fe = e; fa = bus.ex_rs_data_i[p]; end
      end
    end
    m_chk   = sat(m_chk + nq, 65535);
    m_chk_s = sat(m_chk_s + nq, 3);
    m_err   = sat((err_clr ? 0 : m_err) + nf, 65535);
    m_err_s = sat((err_clr ? 0 : m_err_s) + nf, 3);
    m_error = (err_clr ? 1'b0 : m_error) | (nf > 0);
    m_mm    = (nf > 0);
    m_port  = (nf > 0) ? first : 0;
    if (nf > 0) begin m_exp = fe; m_act = fa; end
    if (bus.retire_we_i && bus.retire_rd_i != 5'd0) m_shadow[bus.retire_rd_i] = bus.retire_data_i;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".mm"},     {31'd0, mm},    {31'd0, m_mm});
    check({tag, ".port"},   {31'd0, mport}, m_port);
    check({tag, ".exp"},    mexp,           m_exp);
    check({tag, ".act"},    mact,           m_act);
    check({tag, ".err"},    {31'd0, err},   {31'd0, m_error});
    check({tag, ".chk"},    32'(chkc),      m_chk);
    check({tag, ".errc"},   32'(errc),      m_err);
    check({tag, ".s_mm"},   {31'd0, mm_s},  {31'd0, m_mm});
    check({tag, ".s_chk"},  32'(chkc_s),    m_chk_s);
    check({tag, ".s_errc"}, 32'(errc_s),    m_err_s);
    check({tag, ".s_err"},  {31'd0, err_s}, {31'd0, m_error});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        valid, stall, flush, clr;
    logic [1:0]  used;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  swe;
    logic [4:0]  rd0, rd1;
    logic [31:0] sd0, sd1;
    logic        rwe;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic        e_mm, e_port, e_err;
    logic [31:0] e_exp, e_act;
    logic [15:0] e_chk, e_errc;
    logic [1:0]  e_errc_s;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic apply(input vec_t v);
    bus.ex_valid_i      = v.valid;
    bus.stall_i         = v.stall;
    bus.flush_i         = v.flush;
    err_clr             = v.clr;
    bus.ex_rs_used_i    = v.used;
    bus.ex_rs_addr_i[0] = v.a0;
    bus.ex_rs_addr_i[1] = v.a1;
    bus.ex_rs_data_i[0] = v.d0;
    bus.ex_rs_data_i[1] = v.d1;
    bus.stage_we_i      = v.swe;
    bus.stage_rd_i[0]   = v.rd0;
    bus.stage_rd_i[1]   = v.rd1;
    bus.stage_data_i[0] = v.sd0;
    bus.stage_data_i[1] = v.sd1;
    bus.retire_we_i     = v.rwe;
    bus.retire_rd_i     = v.rrd;
    bus.retire_data_i   = v.rdata;
  endtask

  task automatic build_table();
    for (int i = 0; i < NV; i++) tbl[i] = '0;
    // retire x5 = 0x11
    tbl[0].rwe = 1; tbl[0].rrd = 5; tbl[0].rdata = 32'h11;
    // EX reads x5 correctly
    tbl[1].valid = 1; tbl[1].used = 2'b01; tbl[1].a0 = 5; tbl[1].d0 = 32'h11;
    tbl[1].e_chk = 1;
    // stage0 x3=A, stage1 x3=B, port1 gets stale B
    tbl[2].valid = 1; tbl[2].used = 2'b10; tbl[2].a1 = 3; tbl[2].d1 = 32'hB;
    tbl[2].swe = 2'b11; tbl[2].rd0 = 3; tbl[2].rd1 = 3; tbl[2].sd0 = 32'hA; tbl[2].sd1 = 32'hB;
    tbl[2].e_mm = 1; tbl[2].e_port = 1; tbl[2].e_exp = 32'hA; tbl[2].e_act = 32'hB;
    tbl[2].e_err = 1; tbl[2].e_chk = 2; tbl[2].e_errc = 1; tbl[2].e_errc_s = 1;
    // x0 read with garbage while stage0 "writes" x0
    tbl[3].valid = 1; tbl[3].used = 2'b01; tbl[3].a0 = 0; tbl[3].d0 = 32'hFFFF_FFFF;
    tbl[3].swe = 2'b01; tbl[3].rd0 = 0; tbl[3].sd0 = 32'h55;
    tbl[3].e_mm = 1; tbl[3].e_exp = 0; tbl[3].e_act = 32'hFFFF_FFFF;
    tbl[3].e_err = 1; tbl[3].e_chk = 3; tbl[3].e_errc = 2; tbl[3].e_errc_s = 2;
    // wrong operand under stall for three cycles
    for (int i = 4; i <= 6; i++) begin
      tbl[i].valid = 1; tbl[i].stall = 1; tbl[i].used = 2'b01; tbl[i].a0 = 5; tbl[i].d0 = 32'hDEAD;
      tbl[i].e_act = 32'hFFFF_FFFF; tbl[i].e_err = 1; tbl[i].e_chk = 3; tbl[i].e_errc = 2; tbl[i].e_errc_s = 2;
    end
    // release with correct operand
    tbl[7] = tbl[4]; tbl[7].stall = 0; tbl[7].d0 = 32'h11; tbl[7].e_chk = 4;
    // wrong operand but flushed
    tbl[8] = tbl[4]; tbl[8].stall = 0; tbl[8].flush = 1; tbl[8].e_chk = 4;
    // both ports fail with a simultaneous clear
    tbl[9].valid = 1; tbl[9].used = 2'b11; tbl[9].a0 = 5; tbl[9].a1 = 5; tbl[9].d0 = 1; tbl[9].d1 = 2;
    tbl[9].clr = 1; tbl[9].e_mm = 1; tbl[9].e_exp = 32'h11; tbl[9].e_act = 1;
    tbl[9].e_err = 1; tbl[9].e_chk = 6; tbl[9].e_errc = 2; tbl[9].e_errc_s = 2;
    // clear alone
    tbl[10].clr = 1; tbl[10].e_exp = 32'h11; tbl[10].e_act = 1; tbl[10].e_chk = 6;
    // two double failures back to back: 2-bit counter saturates
    for (int i = 11; i <= 12; i++) begin
      tbl[i].valid = 1; tbl[i].used = 2'b11; tbl[i].a0 = 5; tbl[i].a1 = 5;
      tbl[i].e_mm = 1; tbl[i].e_exp = 32'h11; tbl[i].e_act = 0; tbl[i].e_err = 1;
    end
    tbl[11].e_chk = 8;  tbl[11].e_errc = 2; tbl[11].e_errc_s = 2;
    tbl[12].e_chk = 10; tbl[12].e_errc = 4; tbl[12].e_errc_s = 3;
    // same-cycle retire and read of x7
    tbl[13].valid = 1; tbl[13].used = 2'b01; tbl[13].a0 = 7; tbl[13].d0 = 32'h77;
    tbl[13].rwe = 1; tbl[13].rrd = 7; tbl[13].rdata = 32'h77;
    tbl[13].e_exp = 32'h11; tbl[13].e_err = 1; tbl[13].e_chk = 11; tbl[13].e_errc = 4; tbl[13].e_errc_s = 3;
    // x7 now served by the shadow file
    tbl[14] = tbl[13]; tbl[14].rwe = 0; tbl[14].rrd = 0; tbl[14].rdata = 0; tbl[14].e_chk = 12;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  initial begin
    vec_t idle;
    idle = '0;
    apply(idle);
    model_reset();
    build_table();

    // reset state
    #12;
    check("reset.mm", {31'd0, mm}, 0);
    check("reset.chk", 32'(chkc), 0);
    check("reset.err", {31'd0, err}, 0);
    @(negedge clk);
    reset = 1'b1;

    // directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.mm_t", i),   {31'd0, mm},    {31'd0, tbl[i].e_mm});
      check($sformatf("vec%0d.port_t", i), {31'd0, mport}, {31'd0, tbl[i].e_port});
      check($sformatf("vec%0d.exp_t", i),  mexp,           tbl[i].e_exp);
      check($sformatf("vec%0d.act_t", i),  mact,           tbl[i].e_act);
      check($sformatf("vec%0d.err_t", i),  {31'd0, err},   {31'd0, tbl[i].e_err});
      check($sformatf("vec%0d.chk_t", i),  32'(chkc),      32'(tbl[i].e_chk));
      check($sformatf("vec%0d.errc_t", i), 32'(errc),      32'(tbl[i].e_errc));
      check($sformatf("vec%0d.serr_t", i), 32'(errc_s),    32'(tbl[i].e_errc_s));
    end

    // reset asserted mid-stream clears everything at once
    @(negedge clk);
    apply(tbl[12]);
    cycle("pre_rst");
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst.mm",    {31'd0, mm},    0);
    check("rst.exp",   mexp,           0);
    check("rst.act",   mact,           0);
    check("rst.err",   {31'd0, err},   0);
    check("rst.chk",   32'(chkc),      0);
    check("rst.errc",  32'(errc),      0);
    check("rst.serrc", 32'(errc_s),    0);
    check("rst.schk",  32'(chkc_s),    0);
    apply(idle);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // shadow file was cleared: x7 now reads as zero
    @(negedge clk);
    begin
      vec_t v;
      v = idle; v.valid = 1; v.used = 2'b01; v.a0 = 7; v.d0 = 0;
      apply(v);
    end
    cycle("post_rst");
    check("post_rst.chk", 32'(chkc), 1);
    check("post_rst.mm",  {31'd0, mm}, 0);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.ex_valid_i   = ($urandom_range(0, 7) != 0);
      bus.stall_i      = ($urandom_range(0, 4) == 0);
      bus.flush_i      = ($urandom_range(0, 6) == 0);
      err_clr          = ($urandom_range(0, 15) == 0);
      bus.ex_rs_used_i = 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        bus.stage_we_i[s]   = $urandom_range(0, 1) == 1;
        bus.stage_rd_i[s]   = 5'($urandom_range(0, 7));
        bus.stage_data_i[s] = $urandom;
      end
      bus.retire_we_i   = $urandom_range(0, 1) == 1;
      bus.retire_rd_i   = 5'($urandom_range(0, 7));
      bus.retire_data_i = $urandom;
      for (int p = 0; p < 2; p++) begin
        bus.ex_rs_addr_i[p] = 5'($urandom_range(0, 7));
        bus.ex_rs_data_i[p] = ($urandom_range(0, 4) == 0) ? $urandom
                                                           : m_expect(bus.ex_rs_addr_i[p]);
      end
      cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_forwarding_monitor
`default_nettype wire
